// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request scheduler.
// Contents:
//   fop_t          opcode encoding understood by the FPU unit bank
//   sched_state_t  scheduler FSM states (also visible on the debug port)
//   OP_W_DEF       default opcode width
//   TIMEOUT_DEF    default WAIT-state cycle budget before a forced error completion
package fpu_pkg;

  localparam int OP_W_DEF    = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [3:0] {
    FADD  = 4'd0,
    FSUB  = 4'd1,
    FMUL  = 4'd2,
    FDIV  = 4'd3,
    FSQRT = 4'd4,
    FEQ   = 4'd5,
    FLESS = 4'd6,
    FTOI  = 4'd7,
    ITOF  = 4'd8
  } fop_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   i_valid [1:0]  request valid per port
//   i_ptr          preferred port when both are valid
//   o_grant [1:0]  one-hot grant (all zero when nothing is valid)
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fpu_req_sched.sv
// Shares one FPU unit bank between two requesters (port 0 = core issue,
// port 1 = auxiliary). One operation in flight at a time.
//
// Handshakes: a request transfers on a cycle where req_valid[i] & req_ready[i];
// a response transfers on a cycle where rsp_valid & rsp_ready. rsp_* hold
// steady while rsp_valid is high and not yet accepted. req_ready is only ever
// high in IDLE and never for both ports at once.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/ready [1:0]   per-port request handshake
//   req_op/x1/x2/tag        per-port request payload, port i in slice i
//   fpu_op/x1/x2            registered operands to the unit bank
//   fpu_start               one-cycle start pulse
//   fpu_y, fpu_idle         unit result and idle/result-valid flag
//   rsp_valid/ready         response handshake
//   rsp_y/tag/src/err       response payload (err=1 means timeout, y=0)
//   dbg_state               current FSM state
module fpu_req_sched
  import fpu_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [63:0]         req_x1,
  input  logic [63:0]         req_x2,
  input  logic [2*TAG_W-1:0]  req_tag,
  output logic [OP_W-1:0]     fpu_op,
  output logic [31:0]         fpu_x1,
  output logic [31:0]         fpu_x2,
  output logic                fpu_start,
  input  logic [31:0]         fpu_y,
  input  logic                fpu_idle,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_y,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_src,
  output logic                rsp_err,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_t      r_state, w_state_nxt;
  logic              r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_op;
  logic [31:0]       r_x1, r_x2, r_rsp_y;
  logic [TAG_W-1:0]  r_tag;
  logic              r_src, r_err;
  logic [1:0]        w_grant, w_hs;
  logic              w_accept, w_sel, w_timeout;

  rr_arb2 u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign req_ready = (r_state == S_IDLE) ? w_grant : 2'b00;
  assign w_hs      = req_valid & req_ready;
  assign w_accept  = |w_hs;
  assign w_sel     = w_hs[1];
  // Only reached when the unit stays busy for the whole budget.
  assign w_timeout = (r_state == S_WAIT) && !fpu_idle && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (fpu_idle || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_tag   <= '0;
      r_src   <= 1'b0;
      r_rsp_y <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= w_sel ? req_op[OP_W +: OP_W]   : req_op[0 +: OP_W];
        r_x1  <= w_sel ? req_x1[63:32]          : req_x1[31:0];
        r_x2  <= w_sel ? req_x2[63:32]          : req_x2[31:0];
        r_tag <= w_sel ? req_tag[TAG_W +: TAG_W] : req_tag[0 +: TAG_W];
        r_src <= w_sel;
        // The port just served loses priority for the next contested cycle.
        r_ptr <= ~w_sel;
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      if (r_state == S_WAIT) begin
        if (fpu_idle) begin
          r_rsp_y <= fpu_y;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_y <= '0;
          r_err   <= 1'b1;
        end else if (r_cnt != CNT_LAST) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign fpu_op    = r_op;
  assign fpu_x1    = r_x1;
  assign fpu_x2    = r_x2;
  assign fpu_start = (r_state == S_ISSUE);
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_y     = r_rsp_y;
  assign rsp_tag   = r_tag;
  assign rsp_src   = r_src;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fpu_req_sched.sv
module tb_fpu_req_sched;
  import fpu_pkg::*;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_x1, req_x2;
  logic [11:0] req_tag;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_x1, fpu_x2, fpu_y, rsp_y;
  logic        fpu_start, fpu_idle, rsp_valid, rsp_ready, rsp_src, rsp_err;
  logic [5:0]  rsp_tag;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_pass = 0;

  fpu_req_sched #(.OP_W(4), .TAG_W(6), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .fpu_op(fpu_op), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_start(fpu_start),
    .fpu_y(fpu_y), .fpu_idle(fpu_idle), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_tag(rsp_tag), .rsp_src(rsp_src), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [5:0] tag);
    req_op[p*4 +: 4]  = op;
    req_x1[p*32 +: 32] = x1;
    req_x2[p*32 +: 32] = x2;
    req_tag[p*6 +: 6] = tag;
  endtask

  // Counts negedges without rsp_valid; returns at the negedge where it is seen.
  task automatic wait_rsp(input int budget, output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    chk("rsp_arrives", 32'(ok), 32'd1);
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Transaction timeline: accept at cycle A, start pulse at A+1, unit result
  // sampled from A+2 onward, response visible from the cycle after the result
  // (or after TMO busy cycles) until rsp_ready is seen.
  logic [6:0] exp_q[$];
  int  m_cyc = 0, m_acc = 0, m_done = -1;
  bit  m_busy = 0, m_ptr = 0, m_armed = 0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_x1 = '0, m_x2 = '0, m_y = '0;
  logic [5:0]  m_tag = '0;
  bit  m_src = 0, m_err = 0;

  always @(negedge clk) begin
    logic [1:0] e_ready;
    logic e_start, e_valid;
    logic [6:0] e_id;
    e_ready = 2'b00;
    e_start = 1'b0;
    e_valid = 1'b0;
    if (!m_busy) begin
      if (req_valid == 2'b11) e_ready = m_ptr ? 2'b10 : 2'b01;
      else                    e_ready = req_valid;
    end else if (m_cyc == m_acc + 1) begin
      e_start = 1'b1;
    end else if (m_done >= 0 && m_cyc >= m_done) begin
      e_valid = 1'b1;
    end

    if (m_armed) begin
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_fpu_start", 32'(fpu_start), 32'(e_start));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("m_fpu_op", 32'(fpu_op), 32'(m_op));
      chk("m_fpu_x1", fpu_x1, m_x1);
      chk("m_fpu_x2", fpu_x2, m_x2);
      if (e_valid) begin
        chk("m_rsp_y", rsp_y, m_y);
        chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
        if (rsp_ready) begin
          if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
          else begin
            e_id = exp_q.pop_front();
            chk("sb_src_tag", 32'({rsp_src, rsp_tag}), 32'(e_id));
          end
        end
      end
    end

    if (reset) begin
      m_armed = 1'b1;
      m_busy = 1'b0; m_ptr = 1'b0; m_done = -1;
      m_op = '0; m_x1 = '0; m_x2 = '0; m_y = '0; m_tag = '0; m_src = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (e_ready != 2'b00) begin
        m_src  = e_ready[1];
        m_op   = req_op[m_src*4 +: 4];
        m_x1   = req_x1[m_src*32 +: 32];
        m_x2   = req_x2[m_src*32 +: 32];
        m_tag  = req_tag[m_src*6 +: 6];
        m_ptr  = ~m_src;
        m_busy = 1'b1;
        m_acc  = m_cyc;
        m_done = -1;
        exp_q.push_back({m_src, m_tag});
      end
    end else if (e_valid) begin
      if (rsp_ready) m_busy = 1'b0;
    end else if (m_cyc >= m_acc + 2) begin
      if (fpu_idle) begin
        m_y = fpu_y; m_err = 1'b0; m_done = m_cyc + 1;
      end else if (m_cyc - (m_acc + 2) == TMO - 1) begin
        m_y = '0; m_err = 1'b1; m_done = m_cyc + 1;
      end
    end
    m_cyc++;
  end

  // ---------------- driver ----------------
  initial begin
    int n, mode;
    logic [31:0] y0;
    logic [5:0]  t0;
    logic        s0;
    reset = 1'b1; req_valid = '0; req_op = '0; req_x1 = '0; req_x2 = '0; req_tag = '0;
    fpu_y = '0; fpu_idle = 1'b1; rsp_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(fpu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_rsp_tag_src", 32'({rsp_src, rsp_tag}), 32'd0);

    // 1: FLESS on port 0, combinational unit
    step(); reset = 1'b0;
    set_req(0, FLESS, 32'h3f800000, 32'h40000000, 6'h05);
    req_valid = 2'b01; fpu_y = 32'd1; fpu_idle = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); chk("t1_accept", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    @(negedge clk);
    chk("t1_start", 32'(fpu_start), 32'd1);
    chk("t1_op", 32'(fpu_op), 32'(FLESS));
    chk("t1_x1", fpu_x1, 32'h3f800000);
    step();
    @(negedge clk); chk("t1_not_yet", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_y", rsp_y, 32'd1);
    chk("t1_src_tag", 32'({rsp_src, rsp_tag}), 32'h05);
    step();

    // 2: both valid after reset -> 0,1,0,1
    reset = 1'b1; step(); reset = 1'b0;
    set_req(0, FADD, 32'h1, 32'h2, 6'd1);
    set_req(1, FMUL, 32'h3, 32'h4, 6'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(20, n);
      chk("t2_src", 32'(rsp_src), 32'(k % 2));
      chk("t2_tag", 32'(rsp_tag), (k % 2 == 1) ? 32'd2 : 32'd1);
      step();
    end
    req_valid = 2'b00;

    // 3: FDIV, unit busy for 10 cycles starting at the start cycle
    step();
    set_req(0, FDIV, 32'h40400000, 32'h40000000, 6'd9);
    req_valid = 2'b01; fpu_idle = 1'b0; fpu_y = 32'h3fc00000;
    @(negedge clk); chk("t3_accept", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    @(negedge clk); chk("t3_start", 32'(fpu_start), 32'd1);
    for (int i = 1; i < 10; i++) begin
      step();
      @(negedge clk); chk("t3_busy", 32'(rsp_valid), 32'd0);
    end
    step(); fpu_idle = 1'b1;
    @(negedge clk); chk("t3_idle_cycle", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t3_rsp_y", rsp_y, 32'h3fc00000);
    chk("t3_tag", 32'(rsp_tag), 32'd9);
    step();

    // 4: timeout, then a normal request
    set_req(0, FSQRT, 32'h40800000, 32'h0, 6'd3);
    req_valid = 2'b01; fpu_idle = 1'b0;
    @(negedge clk); chk("t4_accept", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    wait_rsp(TMO + 20, n);
    chk("t4_latency", 32'(n), 32'(TMO + 1));
    chk("t4_err", 32'(rsp_err), 32'd1);
    chk("t4_y", rsp_y, 32'd0);
    step();
    set_req(1, ITOF, 32'd7, 32'd0, 6'd7);
    req_valid = 2'b10; fpu_idle = 1'b1; fpu_y = 32'h12345678;
    wait_rsp(10, n);
    chk("t4b_latency", 32'(n), 32'd3);
    chk("t4b_err", 32'(rsp_err), 32'd0);
    chk("t4b_y", rsp_y, 32'h12345678);
    chk("t4b_src", 32'(rsp_src), 32'd1);
    step(); req_valid = 2'b00;

    // 5: backpressure in DONE, then reset mid-WAIT
    step();
    set_req(0, FEQ, 32'h5, 32'h5, 6'd11);
    set_req(1, FSUB, 32'h6, 32'h7, 6'd12);
    req_valid = 2'b11; rsp_ready = 1'b0;
    wait_rsp(10, n);
    y0 = rsp_y; t0 = rsp_tag; s0 = rsp_src;
    for (int i = 0; i < 5; i++) begin
      step(); fpu_y = $urandom;
      @(negedge clk);
      chk("t5_valid_held", 32'(rsp_valid), 32'd1);
      chk("t5_y_stable", rsp_y, y0);
      chk("t5_tag_src_stable", 32'({rsp_src, rsp_tag}), 32'({s0, t0}));
      chk("t5_no_ready", 32'(req_ready), 32'd0);
    end
    step(); rsp_ready = 1'b1;
    step(); req_valid = 2'b00;
    step();
    set_req(0, FADD, 32'h9, 32'h9, 6'd4);
    req_valid = 2'b01; fpu_idle = 1'b0;
    @(negedge clk); chk("t5_accept", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    step();
    step(); reset = 1'b1;
    @(negedge clk); chk("t5_in_wait", 32'(dbg_state), 32'(S_WAIT));
    step(); reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_state", 32'(dbg_state), 32'd0);
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_op", 32'(fpu_op), 32'd0);

    // random traffic against the model
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c % 250 == 0) mode = $urandom_range(0, 2);
      reset     = ($urandom_range(0, 499) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req_op    = 8'($urandom);
      req_x1    = {$urandom, $urandom};
      req_x2    = {$urandom, $urandom};
      req_tag   = 12'($urandom);
      fpu_y     = $urandom;
      fpu_idle  = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    step(); reset = 1'b0; req_valid = 2'b00;
    repeat (3) step();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
